imem_boot_loader: RTL
=====================

# imem_boot_loader

Byte-stream program loader sitting directly upstream of the single-cycle MIPS processor. It receives a length-prefixed program image over a valid/ready byte interface, assembles big-endian 32-bit words and writes them into instruction memory. It holds the processor in reset until the whole image is written, then releases it so execution starts at PC 0.

## Interface
- ADDR_WIDTH, 8: instruction-memory word-address width.
- MAX_WORDS, 256: largest accepted image in words. Must be ≤ 2^ADDR_WIDTH.

- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data holds a valid byte.
- in_data  input  8  image byte.
- in_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr  output  ADDR_WIDTH  word address of the write.
- imem_wdata  output  32  word being written.
- cpu_reset  output  1  active-high hold for the processor.
- done  output  1  image fully loaded (sticky).
- error  output  1  image rejected (sticky).
- word_count  output  16  header word count N, as latched.

## Operation
- Image format:
  - 2-byte header N, high byte first.
  - Then N words of 4 bytes each, most-significant byte first.
  - With CHECKSUM_EN, one trailing checksum byte follows the words.
- A byte transfers only on a rising edge where in_valid && in_ready. in_data is ignored otherwise.
- States and transitions:
  - HDR_HI: capture N[15:8]; go to HDR_LO.
  - HDR_LO: capture N[7:0], then decide:
    - N == 0: go to DONE (or CHK with CHECKSUM_EN).
    - N > MAX_WORDS: go to ERROR.
    - Otherwise: go to DATA.
  - DATA: shift each byte into a 32-bit assembly register and count bytes 0–3. When byte 3 transfers, go to WRITE.
  - WRITE: one cycle with imem_we=1, imem_addr = word index, imem_wdata = assembled word.
    - Then increment the word index.
    - If index+1 == N, go to DONE (or CHK); otherwise return to DATA.
  - CHK (CHECKSUM_EN only): one byte. If it equals the running checksum go to DONE, otherwise go to ERROR.
  - DONE: terminal. cpu_reset=0, done=1.
  - ERROR: terminal. cpu_reset=1, error=1, in_ready=0.
- in_ready = 1 in HDR_HI, HDR_LO, DATA and CHK; 0 in WRITE, DONE and ERROR.
- cpu_reset = 1 in every state except DONE.
- Word index width is ADDR_WIDTH+1, so the N == 2^ADDR_WIDTH boundary is detected correctly. imem_addr carries the low ADDR_WIDTH bits and never wraps during a valid load.
- Bytes presented in DONE or ERROR are never accepted. The upstream must stop.
- Only reset leaves DONE or ERROR.

## Timing
- Reset (asynchronous assert) forces:
  - state HDR_HI, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0;
  - cpu_reset=1, done=0, error=0, word_count=0;
  - checksum and byte counters cleared.
- in_ready rises in the first clk cycle after reset deasserts.
- Byte-to-write latency: the imem_we cycle directly follows the edge on which the 4th byte of a word transfers.
- Peak throughput: 1 word per 5 cycles with in_valid held high.
- Release timing:
  - Without CHECKSUM_EN, cpu_reset falls and done rises on the edge that ends the final WRITE cycle.
  - With CHECKSUM_EN, they change on the edge where the checksum byte transfers.
- in_valid may drop at any point. The loader waits indefinitely in its current state, and the partial word is retained.
- Reset asserted mid-load aborts the load: the partial word is discarded and no further imem_we pulses occur. Already-written words remain in memory.

## Configuration
- IMEM_BOOT_CHECKSUM_EN defined:
  - The checksum is the XOR of all header and data bytes, computed as they transfer.
  - The trailing byte is compared in state CHK. A mismatch goes to ERROR and the processor stays in reset.
- IMEM_BOOT_CHECKSUM_EN undefined:
  - No CHK state and no trailing byte.
  - DONE follows the last WRITE (or HDR_LO when N == 0) directly.

## Test plan
- Header 00 02, then bytes 20 08 00 05, 20 09 00 07, always valid:
  - Required: imem_we at addr 0 with data 0x20080005, then addr 1 with data 0x20090007.
  - word_count=2.
  - done=1 and cpu_reset=0 after the second write.
- Header 00 00:
  - Required: no imem_we; done=1 at the next edge (without CHECKSUM_EN).
- Header 01 01 with MAX_WORDS=256:
  - Required: error=1, in_ready=0, cpu_reset stays 1, no writes.
- Same 2-word image with in_valid toggling every other cycle:
  - Required: identical writes and values; only timing stretches.
- Reset asserted after 6 data bytes, then the 1-word image 00 01 AA BB CC DD:
  - Required: a single write at addr 0 with data 0xAABBCCDD; done=1.
- CHECKSUM_EN, image 00 01 11 22 33 44:
  - Trailing byte 0x45: done=1.
  - Trailing byte 0x00: error=1, cpu_reset=1.

Source files
------------

// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Receives a length-prefixed program image over a valid/ready byte stream,
//   packs big-endian 32-bit words and writes them into instruction memory.
//   It holds the processor in reset until the whole image has been written.
//
//   Image: N[15:8], N[7:0], then N words of 4 bytes each (MSB first),
//   then one XOR checksum byte when IMEM_BOOT_CHECKSUM_EN is defined.
//
//   Optional feature macro: IMEM_BOOT_CHECKSUM_EN (trailing checksum byte).
//
//   Ports
//     clk         system clock, rising edge
//     reset       asynchronous reset, active low
//     in_valid    in_data holds a byte
//     in_data     image byte
//     in_ready    loader takes a byte this cycle
//     imem_we     instruction-memory write strobe, one cycle per word
//     imem_addr   word address of the write
//     imem_wdata  word being written
//     cpu_reset   active-high processor hold; low only once the load is done
//     done        image fully loaded (sticky)
//     error       image rejected (sticky)
//     word_count  header word count N, as latched
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   S_HDR_HI | waiting for header high byte
//   S_HDR_LO | waiting for header low byte, then range check on N
//   S_DATA   | collecting the 4 bytes of the current word
//   S_WRITE  | one-cycle instruction-memory write
//   S_CHK    | waiting for the trailing checksum byte
//   S_DONE   | image loaded, processor released (terminal)
//   S_ERROR  | image rejected, processor held (terminal)
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           word_count
);

  typedef enum logic [2:0] {
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t              state;
  logic [1:0]          byte_cnt;
  // Only the first three bytes need storing; the fourth goes straight out.
  logic [23:0]         asm_q;
  // One bit wider than the address so N == 2^ADDR_WIDTH terminates cleanly.
  logic [ADDR_WIDTH:0] word_idx;

  logic                xfer;
  logic [15:0]         hdr_n;
  logic [ADDR_WIDTH:0] idx_next;
  logic                word_last;
  logic                hdr_too_big;

  assign xfer        = in_valid & in_ready;
  assign hdr_n       = {word_count[15:8], in_data};
  assign idx_next    = word_idx + 1'b1;
  assign word_last   = (32'(idx_next) == 32'(word_count));
  assign hdr_too_big = (32'(hdr_n) > 32'(MAX_WORDS));

`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum <= 8'h00;
    end else if (xfer && (state == S_HDR_HI || state == S_HDR_LO || state == S_DATA)) begin
      csum <= csum ^ in_data;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_HDR_HI;
      byte_cnt   <= 2'd0;
      asm_q      <= 24'h0;
      word_idx   <= '0;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'h0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= 16'h0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_HDR_HI: begin
          // in_ready is registered, so it first goes high one edge after reset.
          in_ready <= 1'b1;
          if (xfer) begin
            word_count[15:8] <= in_data;
            state            <= S_HDR_LO;
          end
        end

        S_HDR_LO: begin
          if (xfer) begin
            word_count[7:0] <= in_data;
            if (hdr_n == 16'h0) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
              state     <= S_CHK;
`else
              state     <= S_DONE;
              in_ready  <= 1'b0;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
`endif
            end else if (hdr_too_big) begin
              state    <= S_ERROR;
              in_ready <= 1'b0;
              error    <= 1'b1;
            end else begin
              state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (xfer) begin
            asm_q    <= {asm_q[15:0], in_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              // Strobe is registered here so it lands in the WRITE cycle.
              state      <= S_WRITE;
              in_ready   <= 1'b0;
              imem_we    <= 1'b1;
              imem_addr  <= word_idx[ADDR_WIDTH-1:0];
              imem_wdata <= {asm_q, in_data};
            end
          end
        end

        S_WRITE: begin
          word_idx <= idx_next;
          if (word_last) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
            state    <= S_CHK;
            in_ready <= 1'b1;
`else
            state     <= S_DONE;
            done      <= 1'b1;
            cpu_reset <= 1'b0;
`endif
          end else begin
            state    <= S_DATA;
            in_ready <= 1'b1;
          end
        end

`ifdef IMEM_BOOT_CHECKSUM_EN
        S_CHK: begin
          if (xfer) begin
            in_ready <= 1'b0;
            if (in_data == csum) begin
              state     <= S_DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
            end
          end
        end
`endif

        S_DONE: begin
          in_ready <= 1'b0;
        end

        S_ERROR: begin
          in_ready <= 1'b0;
        end

        default: begin
          state    <= S_ERROR;
          in_ready <= 1'b0;
          error    <= 1'b1;
        end
      endcase
    end
  end

endmodule
